// File: rtl/imm_gen_if.sv
// -----------------------------------------------------------------------------
// imm_gen_if -- handshake bundle for imm_gen_pipe.
//
// Input side (producer -> block):
//   in_valid   instruction word present on in_instr
//   in_instr   32-bit RV32I instruction word
//   in_ready   block can accept an instruction this cycle
// Output side (block -> consumer):
//   out_valid    head entry is valid
//   out_ready    consumer accepts the head entry this cycle
//   out_imm      decoded, extended immediate (XLEN bits)
//   out_fmt      format code 0 R,1 I,2 S,3 B,4 U,5 J,6 Z,7 illegal
//   out_illegal  head entry carried an unsupported opcode
//
// Modports: slave is the block side, master is the environment side
// (drives instructions and consumes results).
// -----------------------------------------------------------------------------
interface imm_gen_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [31:0]     in_instr;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe -- RV32I immediate decoder feeding a 2-entry output FIFO.
//
// Each accepted instruction is decoded into {imm, fmt, illegal} and buffered;
// the FIFO head is presented on the output side of the interface. There is no
// combinational path from the input side to the output side: a word pushed in
// cycle N is visible at the head from cycle N+1.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-low reset
//   bus          imm_gen_if.slave (in_valid/in_instr/in_ready,
//                out_valid/out_ready/out_imm/out_fmt/out_illegal)
//   illegal_cnt  saturating count of accepted illegal instructions
//
// Parameters:
//   XLEN   immediate width, 32 or 64 (must match the interface XLEN)
//   CNT_W  width of illegal_cnt
//
// Build option:
//   IMM_GEN_ZICSR_EN  when defined, SYSTEM opcode 1110011 decodes as CSR:
//                     funct3[2]=1 -> fmt Z (zero-extended rs1 field as zimm),
//                     funct3[2]=0 -> fmt I. When undefined it is illegal.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  imm_gen_if.slave         bus,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Widen a 32-bit signed immediate to XLEN by replicating bit 31.
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Increment that sticks at the all-ones value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [31:0]        instr_p0;
  logic [6:0]         opc_p0;
  logic signed [31:0] imm32_p0;
  logic [2:0]         fmt_p0;
  logic [XLEN-1:0]    imm_p0;
  logic               ill_p0;

  assign instr_p0 = bus.in_instr;
  assign opc_p0   = instr_p0[6:0];

  always_comb begin
    fmt_p0   = FMT_ILL;
    imm32_p0 = '0;
    unique case (opc_p0)
      7'b0110011: fmt_p0 = FMT_R;
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
        fmt_p0   = FMT_I;
        imm32_p0 = {{20{instr_p0[31]}}, instr_p0[31:20]};
      end
      7'b0100011: begin
        fmt_p0   = FMT_S;
        imm32_p0 = {{20{instr_p0[31]}}, instr_p0[31:25], instr_p0[11:7]};
      end
      7'b1100011: begin
        fmt_p0   = FMT_B;
        imm32_p0 = {{19{instr_p0[31]}}, instr_p0[31], instr_p0[7],
                    instr_p0[30:25], instr_p0[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        fmt_p0   = FMT_U;
        imm32_p0 = {instr_p0[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt_p0   = FMT_J;
        imm32_p0 = {{11{instr_p0[31]}}, instr_p0[31], instr_p0[19:12],
                    instr_p0[20], instr_p0[30:21], 1'b0};
      end
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: begin
        if (instr_p0[14]) begin
          fmt_p0   = FMT_Z;
          imm32_p0 = {27'b0, instr_p0[19:15]};
        end else begin
          fmt_p0   = FMT_I;
          imm32_p0 = {{20{instr_p0[31]}}, instr_p0[31:20]};
        end
      end
`endif
      default: begin
        fmt_p0   = FMT_ILL;
        imm32_p0 = '0;
      end
    endcase
  end

  assign imm_p0 = sext32(imm32_p0);
  assign ill_p0 = (fmt_p0 == FMT_ILL);

  // ---------------------------------------------------------------------------
  // Stage p1: 2-entry FIFO (control reset, data storage unreset)
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  imm_mem_q [2];
  logic [2:0]       fmt_mem_q [2];
  logic             ill_mem_q [2];

  logic [1:0]       cnt_q, cnt_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             push, pop;
  logic             vld_p1;

  // in_ready is low throughout reset so nothing is accepted in a reset cycle.
  assign bus.in_ready = rst && (cnt_q != 2'd2);
  assign vld_p1       = (cnt_q != 2'd0);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = vld_p1 && bus.out_ready && rst;

  always_comb begin
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q ^ push;
    rd_ptr_d  = rd_ptr_q ^ pop;
    ill_cnt_d = ill_cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    if (push && ill_p0) ill_cnt_d = sat_inc(ill_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem_q[wr_ptr_q] <= imm_p0;
      fmt_mem_q[wr_ptr_q] <= fmt_p0;
      ill_mem_q[wr_ptr_q] <= ill_p0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output: head entry, forced to zero when empty so stale or uninitialised
  // storage never reaches the consumer.
  // ---------------------------------------------------------------------------
  assign bus.out_valid   = vld_p1;
  assign bus.out_imm     = vld_p1 ? imm_mem_q[rd_ptr_q] : '0;
  assign bus.out_fmt     = vld_p1 ? fmt_mem_q[rd_ptr_q] : 3'd0;
  assign bus.out_illegal = vld_p1 ? ill_mem_q[rd_ptr_q] : 1'b0;
  assign illegal_cnt     = ill_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe. Two instances share one stimulus stream:
// dut_a (XLEN=32, CNT_W=2) and dut_b (XLEN=64, CNT_W=8).
module tb_imm_gen_pipe;
  logic       clk;
  logic       rst;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b;
  int         tests;
  int         fails;

  imm_gen_if #(.XLEN(32)) ifa ();
  imm_gen_if #(.XLEN(64)) ifb ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_instr  = ifa.in_instr;
  assign ifb.out_ready = ifa.out_ready;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .illegal_cnt(cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .illegal_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Push one word with out_ready high, check the head on both instances,
  // then let it drain.
  task automatic push_chk(input string tag, input logic [31:0] instr,
                          input logic [63:0] exp_imm, input logic [2:0] exp_fmt);
    ifa.out_ready = 1'b1;
    ifa.in_valid  = 1'b1;
    ifa.in_instr  = instr;
    tick();
    ifa.in_valid  = 1'b0;
    chk({tag, "_vld"},   {63'd0, ifa.out_valid},   64'd1);
    chk({tag, "_imm32"}, {32'd0, ifa.out_imm},     {32'd0, exp_imm[31:0]});
    chk({tag, "_imm64"}, ifb.out_imm,              exp_imm);
    chk({tag, "_fmt"},   {61'd0, ifa.out_fmt},     {61'd0, exp_fmt});
    chk({tag, "_ill"},   {63'd0, ifa.out_illegal}, {63'd0, (exp_fmt == 3'd7)});
    tick();
    chk({tag, "_drain"}, {63'd0, ifa.out_valid},   64'd0);
  endtask

  initial begin
    logic [1:0] exp_a [4];
    tests = 0;
    fails = 0;
    exp_a[0] = 2'd1; exp_a[1] = 2'd2; exp_a[2] = 2'd3; exp_a[3] = 2'd3;

    rst           = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.in_instr  = 32'd0;
    ifa.out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_vld",   {63'd0, ifa.out_valid},   64'd0);
    chk("rst_rdy",   {63'd0, ifa.in_ready},    64'd0);
    chk("rst_cnt",   {62'd0, cnt_a},           64'd0);
    chk("rst_imm",   {32'd0, ifa.out_imm},     64'd0);
    chk("rst_fmt",   {61'd0, ifa.out_fmt},     64'd0);
    chk("rst_ill",   {63'd0, ifa.out_illegal}, 64'd0);
    chk("rst_vld_b", {63'd0, ifb.out_valid},   64'd0);
    rst = 1'b1;
    #1;
    chk("rel_rdy",   {63'd0, ifa.in_ready},    64'd1);

    // Decode of each format
    push_chk("addi_m1", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    push_chk("addi_p",  32'h7FF00093, 64'h0000_0000_0000_07FF, 3'd1);
    push_chk("beq_m4",  32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3);
    push_chk("jal_p4",  32'h0040006F, 64'h0000_0000_0000_0004, 3'd5);
    push_chk("sw_m4",   32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2);
    push_chk("lui_p",   32'h123450B7, 64'h0000_0000_1234_5000, 3'd4);
    push_chk("lui_n",   32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4);
    push_chk("add_r",   32'h002081B3, 64'h0000_0000_0000_0000, 3'd0);

    // Back-pressure: fill, stall, then drain in order
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_instr  = 32'h00100093;
    tick();
    ifa.in_instr  = 32'h00200093;
    tick();
    ifa.in_instr  = 32'h00300093;
    chk("full_rdy",  {63'd0, ifa.in_ready},  64'd0);
    tick();
    chk("hold_vld",  {63'd0, ifa.out_valid}, 64'd1);
    chk("hold_imm",  {32'd0, ifa.out_imm},   64'd1);
    chk("hold_rdy",  {63'd0, ifa.in_ready},  64'd0);
    ifa.out_ready = 1'b1;
    tick();
    chk("pop1_imm",  {32'd0, ifa.out_imm},   64'd2);
    chk("pop1_rdy",  {63'd0, ifa.in_ready},  64'd1);
    tick();
    chk("pop2_imm",  {32'd0, ifa.out_imm},   64'd3);
    ifa.in_valid  = 1'b0;
    tick();
    chk("pop3_vld",  {63'd0, ifa.out_valid}, 64'd0);

    // Illegal opcode counting and saturation
    ifa.in_valid = 1'b1;
    ifa.in_instr = 32'h0000007F;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ill_fmt",   {61'd0, ifa.out_fmt},     64'd7);
      chk("ill_imm",   {32'd0, ifa.out_imm},     64'd0);
      chk("ill_flag",  {63'd0, ifa.out_illegal}, 64'd1);
      chk("ill_cnt_a", {62'd0, cnt_a},           {62'd0, exp_a[k]});
      chk("ill_cnt_b", {56'd0, cnt_b},           64'(k + 1));
    end
    ifa.in_valid = 1'b0;
    tick();
    chk("ill_drain", {63'd0, ifa.out_valid}, 64'd0);

    // CSR immediate form
`ifdef IMM_GEN_ZICSR_EN
    push_chk("csrrwi", 32'h3400D073, 64'h0000_0000_0000_0001, 3'd6);
    chk("csr_cnt_b", {56'd0, cnt_b}, 64'd4);
`else
    push_chk("csrrwi", 32'h3400D073, 64'h0000_0000_0000_0000, 3'd7);
    chk("csr_cnt_b", {56'd0, cnt_b}, 64'd5);
`endif
    chk("csr_cnt_a", {62'd0, cnt_a}, 64'd3);

    // Reset with a full FIFO discards everything
    ifa.out_ready = 1'b0;
    ifa.in_valid  = 1'b1;
    ifa.in_instr  = 32'h0000007F;
    tick();
    tick();
    chk("pre_vld",   {63'd0, ifa.out_valid}, 64'd1);
    chk("pre_rdy",   {63'd0, ifa.in_ready},  64'd0);
    rst           = 1'b0;
    ifa.out_ready = 1'b1;
    #1;
    chk("inrst_rdy", {63'd0, ifa.in_ready},  64'd0);
    tick();
    chk("mid_vld",   {63'd0, ifa.out_valid},   64'd0);
    chk("mid_cnt_a", {62'd0, cnt_a},           64'd0);
    chk("mid_cnt_b", {56'd0, cnt_b},           64'd0);
    chk("mid_imm",   {32'd0, ifa.out_imm},     64'd0);
    chk("mid_fmt",   {61'd0, ifa.out_fmt},     64'd0);
    chk("mid_ill",   {63'd0, ifa.out_illegal}, 64'd0);
    rst          = 1'b1;
    ifa.in_valid = 1'b0;
    #1;
    chk("post_rdy",  {63'd0, ifa.in_ready},  64'd1);
    tick();
    chk("post_vld",  {63'd0, ifa.out_valid}, 64'd0);
    chk("post_vldb", {63'd0, ifb.out_valid}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
